// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to the synchronous
// instruction memory and feeds IF/ID through a 2-entry queue that rides out stalls.
module if_fetch_unit #(
  parameter int unsigned     PC_W     = 12,
  parameter int unsigned     INSN_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              go,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   pc_4,
  output logic [INSN_W-1:0] instruction,
  output logic              clear
);

  typedef struct packed {
    logic [PC_W-1:0]   pc_4;
    logic [INSN_W-1:0] insn;
  } entry_t;

  localparam logic [PC_W-1:0] WORD = PC_W'(4);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  entry_t          fifo [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            pop;
  logic            push;
  logic [2:0]      credit_used;

  // With count limited to 0..2 the tail slot is rd_ptr advanced by count, mod 2.
  assign wr_ptr = rd_ptr ^ count[0];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    clear       = 1'b1;
    pc_4        = '0;
    instruction = '0;
    if (count != 2'd0 && !redirect) begin
      clear       = 1'b0;
      pc_4        = fifo[rd_ptr].pc_4;
      instruction = fifo[rd_ptr].insn;
    end
  end

  assign pop  = go && !clear;
  assign push = inflight && !redirect;

  // Slots already promised (buffered + in flight) after this cycle's pop.
  assign credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // Gated by rst_n so no request is seen while the stage is held in reset.
  assign imem_req  = rst_n && (redirect || credit_used < 3'd2);
  assign imem_addr = redirect ? {redirect_pc[PC_W-1:2], 2'b00} : pc;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc          <= imem_addr + WORD;
        inflight_pc <= imem_addr;
      end
      if (redirect) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count alone decides which
  // slots hold valid data, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc_4: inflight_pc + WORD, insn: imem_rdata};
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a driver issues go/redirect/reset and
// queues the expected instruction stream; a negedge monitor checks every cycle.
module tb_if_fetch_unit;

  localparam int unsigned   PC_W     = 12;
  localparam int unsigned   INSN_W   = 32;
  localparam logic [11:0]   RESET_PC = 12'h000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INSN_W-1:0] imem_rdata;
  logic              go;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   pc_4;
  logic [INSN_W-1:0] instruction;
  logic              clear;

  int n_checks = 0;
  int n_errors = 0;

  // Program-order pc_4 values the stage should present on the current path.
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .PC_W    (PC_W),
    .INSN_W  (INSN_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .go         (go),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc_4       (pc_4),
    .instruction(instruction),
    .clear      (clear)
  );

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'hA000_0000 | {20'h0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // A new path starting at a fetch address presents start+4, start+8, ...
  function automatic void refill(input logic [11:0] start);
    logic [11:0] a;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      a = a + 12'd4;
      exp_q.push_back(a);
    end
  endfunction

  // Synchronous instruction memory: data for a request appears after the next edge.
  initial begin
    logic        pend;
    logic [11:0] pa;
    imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      pend = imem_req;
      pa   = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = pend ? mem_word(pa) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: outstanding = fetches issued on this path minus instructions consumed.
  initial begin
    int          since_start;
    int          outstanding;
    int          pop;
    logic [11:0] fetch_next;
    logic [11:0] exp_addr;
    since_start = 0;
    outstanding = 0;
    fetch_next  = RESET_PC;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_clear", 32'(clear), 32'd1);
        check("rst_pc_4", {20'h0, pc_4}, 32'd0);
        check("rst_imem_addr", {20'h0, imem_addr}, {20'h0, RESET_PC});
        since_start = 0;
        outstanding = 0;
        fetch_next  = RESET_PC;
      end else begin
        if (redirect) begin
          since_start = 0;
          outstanding = 0;
        end
        check("clear", 32'(clear), 32'(redirect || since_start < 2));
        if (clear) begin
          check("bubble_pc_4", {20'h0, pc_4}, 32'd0);
          check("bubble_insn", instruction, 32'd0);
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL exp_q: got pc_4 0x%03h expected no presentation at %0t", pc_4, $time);
        end else begin
          check("pc_4", {20'h0, pc_4}, {20'h0, exp_q[0]});
          check("insn", instruction, mem_word(exp_q[0] - 12'd4));
        end
        pop = (go && !clear) ? 1 : 0;
        check("imem_req", 32'(imem_req), 32'(redirect || (outstanding - pop) < 2));
        if (imem_req) begin
          exp_addr = redirect ? {redirect_pc[11:2], 2'b00} : fetch_next;
          check("imem_addr", {20'h0, imem_addr}, {20'h0, exp_addr});
          fetch_next = exp_addr + 12'd4;
        end
        outstanding = outstanding - pop + (imem_req ? 1 : 0);
        check("credit_le_2", 32'(outstanding <= 2), 32'd1);
        if (pop != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        if (since_start < 1000) since_start++;
      end
    end
  end

  task automatic cycle(input logic g, input logic r, input logic [11:0] t);
    @(posedge clk);
    #1;
    go          = g;
    redirect    = r;
    redirect_pc = t;
    if (r) refill({t[11:2], 2'b00});
  endtask

  initial begin
    logic        g;
    logic        r;
    logic [11:0] t;
    rst_n       = 1'b0;
    go          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    refill(RESET_PC);
    #2;
    check("por_clear", 32'(clear), 32'd1);
    check("por_imem_req", 32'(imem_req), 32'd0);
    check("por_insn", instruction, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    go    = 1'b1;

    repeat (20) cycle(1'b1, 1'b0, 12'h000);
    repeat (5)  cycle(1'b0, 1'b0, 12'h000);
    repeat (10) cycle(1'b1, 1'b0, 12'h000);

    // Fill the queue, then redirect with go=1 to an unaligned target.
    repeat (3) cycle(1'b0, 1'b0, 12'h000);
    cycle(1'b1, 1'b1, 12'h2C2);
    repeat (8) cycle(1'b1, 1'b0, 12'h000);

    // Steady state has one fetch in flight; redirect while stalled drops it.
    cycle(1'b0, 1'b1, 12'h5A4);
    repeat (3) cycle(1'b0, 1'b0, 12'h000);
    repeat (6) cycle(1'b1, 1'b0, 12'h000);

    // Address wrap at the top of the PC space.
    cycle(1'b1, 1'b1, 12'hFF8);
    repeat (8) cycle(1'b1, 1'b0, 12'h000);

    // Asynchronous reset mid-cycle with the queue full.
    repeat (3) cycle(1'b0, 1'b0, 12'h000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    refill(RESET_PC);
    #1;
    check("async_clear", 32'(clear), 32'd1);
    check("async_pc_4", {20'h0, pc_4}, 32'd0);
    check("async_imem_req", 32'(imem_req), 32'd0);
    check("async_insn", instruction, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    go    = 1'b1;
    repeat (12) cycle(1'b1, 1'b0, 12'h000);

    repeat (800) begin
      g = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 11) == 0);
      t = 12'($urandom_range(0, 4095));
      cycle(g, r, t);
    end
    repeat (3) cycle(1'b1, 1'b0, 12'h000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
